// File: rtl/mem_access_arbiter.sv
// ---------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares one single-port data memory between the instruction-fetch port (IF)
// and the load/store port (D). In IDLE one request is selected and its fields
// are latched into the memory-side registers. The memory is then driven for
// exactly one access window. After that the fetched word, the load data or a
// store acknowledge goes back to the owner.
//
// Handshake (applies to both request ports):
//   A requester raises *_req_i and holds it, with its address/data fields
//   stable, until it sees *_gnt_o high in the same cycle. *_gnt_o is only
//   asserted while the arbiter is IDLE, so the request is accepted on that
//   clock edge. Requests are ignored outside IDLE, and a request dropped
//   before its grant is never served. *_rvalid_o is a one-cycle pulse with no
//   back-pressure. if_rdata_o/d_rdata_o hold their value until the next
//   capture for the same port.
//
// Timing per accepted request (cycle of gnt = t):
//   t        IDLE    gnt pulse, fields latched
//   t+1      ACCESS  mem_* driven (read or write strobe)
//   t+2..    WAIT    MEM_LAT cycles, mem_* held (loads/fetches only)
//   end      RESP    rvalid pulse; load/fetch: t+2+MEM_LAT, store: t+2
//
// Parameters:
//   MEM_LAT   cycles from end of the access window to valid mem_rdata_i (1..4)
//   DATA_MAX  max consecutive D grants while IF is pending (1..7)
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   if_req_i, if_addr_i            fetch request and word address
//   if_gnt_o, if_rvalid_o          fetch accepted / fetched word valid
//   if_rdata_o                     fetched word
//   d_req_i, d_we_i, d_byte_i      load/store request, store select, byte size
//   d_addr_i, d_wdata_i            data address, store data
//   d_gnt_o, d_rvalid_o            D accepted / load data or store done
//   d_rdata_o                      load result (memory sign-extends lb)
//   mem_addr_o, mem_wdata_o        memory address and write data
//   mem_write_o, mem_read_o        memory strobes
//   mem_byte_o                     byte access (drives is_lb and is_sb)
//   mem_rdata_i                    memory read data
//   busy_o                         high whenever the FSM is not IDLE
//   state_o                        current FSM state, for observation
// ---------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int DATA_MAX = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // instruction-fetch port
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    // load/store port
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic        d_byte_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    // memory side
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic        mem_byte_o,
    input  logic [31:0] mem_rdata_i,
    // status
    output logic        busy_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
    localparam logic [2:0] STREAK_MAX = 3'(DATA_MAX);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    state_e      state_q;
    logic        last_owner_q;  // owner of the access in flight (or the last one)
    logic        we_q;          // access in flight is a store
    logic [2:0]  lat_cnt_q;     // WAIT cycle index, 0..MEM_LAT-1
    logic [2:0]  d_streak_q;    // consecutive D grants taken while IF was waiting

    logic        grant_if;
    logic        grant_d;
    logic        d_is_store;

    // Arbitration is evaluated only in IDLE. D has priority unless it has
    // already taken DATA_MAX grants in a row while IF was waiting. The grant
    // is suppressed during reset because the state update is discarded then.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == S_IDLE && !reset_i) begin
            if (if_req_i && d_req_i) begin
                if (d_streak_q == STREAK_MAX) begin
                    grant_if = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end else if (d_req_i) begin
                grant_d = 1'b1;
            end
        end
    end

    assign d_is_store = grant_d & d_we_i;

    assign if_gnt_o = grant_if;
    assign d_gnt_o  = grant_d;
    assign busy_o   = (state_q != S_IDLE);
    assign state_o  = state_q;

    // The mem_* registers double as the latched request fields. They are
    // loaded on the grant edge, so they are valid for the whole ACCESS/WAIT
    // window. They are cleared on the way into RESP, so the memory sees no
    // strobe outside the window.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWNER_IF;
            we_q         <= 1'b0;
            lat_cnt_q    <= 3'd0;
            d_streak_q   <= 3'd0;
            mem_addr_o   <= 32'd0;
            mem_wdata_o  <= 32'd0;
            mem_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_byte_o   <= 1'b0;
            if_rvalid_o  <= 1'b0;
            d_rvalid_o   <= 1'b0;
            if_rdata_o   <= 32'd0;
            d_rdata_o    <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_if || grant_d) begin
                        last_owner_q <= grant_d ? OWNER_D : OWNER_IF;
                        we_q         <= d_is_store;
                        mem_addr_o   <= grant_d ? d_addr_i : if_addr_i;
                        mem_wdata_o  <= d_is_store ? d_wdata_i : 32'd0;
                        mem_write_o  <= d_is_store;
                        mem_read_o   <= ~d_is_store;
                        mem_byte_o   <= grant_d & d_byte_i;
                        state_q      <= S_ACCESS;
                        // The streak only counts D wins that made IF wait.
                        if (grant_if) begin
                            d_streak_q <= 3'd0;
                        end else if (if_req_i && d_streak_q != STREAK_MAX) begin
                            d_streak_q <= d_streak_q + 3'd1;
                        end
                    end
                end

                S_ACCESS: begin
                    if (we_q) begin
                        // A store completes with the single write strobe.
                        mem_addr_o  <= 32'd0;
                        mem_wdata_o <= 32'd0;
                        mem_write_o <= 1'b0;
                        mem_read_o  <= 1'b0;
                        mem_byte_o  <= 1'b0;
                        d_rvalid_o  <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_cnt_q <= 3'd0;
                        state_q   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        if (last_owner_q == OWNER_D) begin
                            d_rdata_o  <= mem_rdata_i;
                            d_rvalid_o <= 1'b1;
                        end else begin
                            if_rdata_o  <= mem_rdata_i;
                            if_rvalid_o <= 1'b1;
                        end
                        mem_addr_o  <= 32'd0;
                        mem_wdata_o <= 32'd0;
                        mem_write_o <= 1'b0;
                        mem_read_o  <= 1'b0;
                        mem_byte_o  <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 3'd1;
                    end
                end

                S_RESP: begin
                    if_rvalid_o <= 1'b0;
                    d_rvalid_o  <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
